// File: rtl/fre_meas_pkg.sv
// fre_meas_pkg: shared FSM states, error codes and parameter defaults for the frequency meter control
package fre_meas_pkg;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int unsigned CLK_FRE_DEF = 200000000;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_ZERO = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CALC, DIV, DONE} state_t;
endpackage

// File: rtl/fre_meas_ctrl_if.sv
// fre_meas_ctrl_if: valid/ready result channel from the frequency meter control to its consumer
interface fre_meas_ctrl_if #(
  parameter int W = fre_meas_pkg::CNT_WIDTH_DEF
);
  logic [W-1:0] fre_out;
  logic fre_valid;
  logic fre_ready;
  logic err;
  logic [1:0] err_code;
  modport master(output fre_out, fre_valid, err, err_code, input fre_ready);
  modport slave(input fre_out, fre_valid, err, err_code, output fre_ready);
endinterface

// File: rtl/fre_meas_ctrl_seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge
module seq_divider #(
  parameter int DW = 64,
  parameter int VW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic done,
  output logic [DW-1:0] quotient
);
  localparam int CW = $clog2(DW);
  logic [VW-1:0] rem, dvs, d, r_in, diff, rem_n;
  logic [DW-1:0] q_in, quo_n;
  logic [VW:0] sh;
  logic [CW-1:0] cnt;
  logic ge;
  always_comb begin
    d = start ? divisor : dvs;
    r_in = start ? '0 : rem;
    q_in = start ? dividend : quotient;
    sh = {r_in, q_in[DW-1]};
    ge = sh >= {1'b0, d};
    diff = sh[VW-1:0] - d;
    rem_n = ge ? diff : sh[VW-1:0];
    quo_n = {q_in[DW-2:0], ge};
  end
  // done stays high after the last step so the quotient can be read at leisure
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem <= rem_n;
      dvs <= divisor;
      quotient <= quo_n;
      cnt <= CW'(DW - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      rem <= rem_n;
      quotient <= quo_n;
      cnt <= cnt - CW'(1);
      done <= cnt == CW'(1);
    end
endmodule

// File: rtl/fre_meas_ctrl.sv
// fre_meas_ctrl: gated-counter measurement sequencer computing fre = sig_cnt*CLK_FRE/gate_cnt
// FRE_ROUND_EN: when defined the division rounds to nearest and takes one extra cycle
module fre_meas_ctrl
  import fre_meas_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned CLK_FRE = CLK_FRE_DEF,
  parameter int SETTLE_MAX = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [CNT_WIDTH-1:0] gate_len,
  output logic busy,
  output logic cnt_clr,
  output logic gate_en,
  input  logic [CNT_WIDTH-1:0] sig_cnt,
  input  logic [CNT_WIDTH-1:0] gate_cnt,
  input  logic cnt_valid,
  fre_meas_ctrl_if.master res
);
`ifdef FRE_ROUND_EN
  localparam int DW = 2 * CNT_WIDTH + 1;
`else
  localparam int DW = 2 * CNT_WIDTH;
`endif
  state_t st, nxt;
  logic [CNT_WIDTH-1:0] tcnt, fre_q, fre_n;
  logic [1:0] err_q, err_n;
  logic [DW-1:0] dividend, quo;
  logic div_start, div_done, ovf, tlast;
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? (gate_len == '0 ? DONE : CLEAR) : IDLE;
      CLEAR:   nxt = GATE;
      GATE:    nxt = tlast ? SETTLE : GATE;
      SETTLE:  nxt = cnt_valid ? CALC : tlast ? DONE : SETTLE;
      CALC:    nxt = gate_cnt == '0 ? DONE : DIV;
      DIV:     nxt = div_done ? DONE : DIV;
      DONE:    nxt = res.fre_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = st != IDLE;
    cnt_clr = st == CLEAR;
    gate_en = st == GATE;
    res.fre_valid = st == DONE;
    res.fre_out = fre_q;
    res.err_code = err_q;
    res.err = err_q != ERR_OK;
  end
  // one down-counter serves as gate length in GATE and as timeout in SETTLE
  always_comb begin
    tlast = tcnt == CNT_WIDTH'(1);
    div_start = st == CALC && gate_cnt != '0;
`ifdef FRE_ROUND_EN
    dividend = DW'(sig_cnt) * DW'(CLK_FRE) + DW'(gate_cnt >> 1);
`else
    dividend = DW'(sig_cnt) * DW'(CLK_FRE);
`endif
    ovf = |quo[DW-1:CNT_WIDTH];
    err_n = st == IDLE ? ERR_OVF : st == SETTLE ? ERR_TIMEOUT : st == CALC ? ERR_ZERO : ovf ? ERR_OVF : ERR_OK;
    fre_n = st != DIV ? '0 : ovf ? '1 : quo[CNT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tcnt <= '0;
      fre_q <= '0;
      err_q <= ERR_OK;
    end else begin
      tcnt <= st == IDLE ? gate_len : st == GATE ? (tlast ? CNT_WIDTH'(SETTLE_MAX) : tcnt - CNT_WIDTH'(1)) : st == SETTLE ? tcnt - CNT_WIDTH'(1) : tcnt;
      if (nxt == DONE && st != DONE) begin
        fre_q <= fre_n;
        err_q <= err_n;
      end
    end
  seq_divider #(.DW(DW), .VW(CNT_WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(dividend),
    .divisor(gate_cnt),
    .done(div_done),
    .quotient(quo)
  );
endmodule

// File: doc/fre_meas_ctrl.md
Name: fre_meas_ctrl

Overview:
Measurement sequencer and result calculator for the gated-counter frequency meter datapath. On a start request it clears the counters and opens a gate of programmable length in clk cycles. It then waits for the datapath's locked counts and computes fre = sig_cnt*CLK_FRE/gate_cnt with a sequential divider. The result is presented on a valid/ready handshake to the readout/host side.

Parameters:
- CNT_WIDTH, 32, width of the counts and of the result
- CLK_FRE, 200000000, reference clock frequency in Hz
- SETTLE_MAX, 1024, max clk cycles to wait for cnt_valid after the gate closes

Ports:
- clk, input, 1, reference clock
- rst, input, 1, asynchronous active-low reset
- start, input, 1, measurement request; sampled only in IDLE
- gate_len, input, CNT_WIDTH, gate length in clk cycles; latched on accept
- busy, output, 1, high in every state except IDLE
- cnt_clr, output, 1, one-cycle clear pulse to the counter datapath
- gate_en, output, 1, gate window to the counter datapath
- sig_cnt, input, CNT_WIDTH, locked signal-edge count
- gate_cnt, input, CNT_WIDTH, locked reference count of the synchronised gate
- cnt_valid, input, 1, datapath counts are stable
- fre_out, output, CNT_WIDTH, frequency result in Hz
- fre_valid, output, 1, result available
- fre_ready, input, 1, consumer accepts the result
- err, output, 1, error flag, qualified by fre_valid
- err_code, output, 2, 0 = ok, 1 = zero gate_cnt, 2 = timeout, 3 = overflow or zero gate_len

Behaviour:
- Reset (rst=0, asynchronous) forces IDLE. All outputs go to 0, including fre_out, fre_valid, err and err_code. The latched gate_len and divider state are cleared.
- FSM states: IDLE, CLEAR, GATE, SETTLE, CALC, DIV, DONE.
- IDLE, start=1:
  - gate_len == 0: go directly to DONE with err_code=3 and fre_out=0.
  - otherwise: latch gate_len and go to CLEAR.
- CLEAR: cnt_clr=1 for exactly 1 cycle, then GATE.
- GATE: gate_en=1 for exactly gate_len cycles, counted by an internal down-counter. Then SETTLE.
- SETTLE:
  - cnt_valid sampled high: go to CALC.
  - SETTLE_MAX cycles with no cnt_valid: go to DONE with err_code=2 and fre_out=0.
- CALC (1 cycle):
  - Register the 2*CNT_WIDTH-bit dividend sig_cnt*CLK_FRE and the divisor gate_cnt.
  - gate_cnt == 0: go to DONE with err_code=1 and fre_out=0.
- DIV: restoring division, 1 quotient bit per cycle, 2*CNT_WIDTH cycles (64 at default).
- DIV result:
  - quotient >= 2^CNT_WIDTH: fre_out saturates to all-ones and err_code=3.
  - otherwise: fre_out = low CNT_WIDTH bits, truncated, and err_code=0.
- Latency: cnt_valid sampled high in cycle N gives fre_valid high from cycle N+2+2*CNT_WIDTH (N+66 at default).
- DONE:
  - fre_valid=1; fre_out, err and err_code are held stable until fre_valid && fre_ready.
  - The transfer cycle returns the FSM to IDLE, and fre_valid drops in the next cycle.
  - If fre_ready is already high on the first DONE cycle, the transfer happens in that same cycle.
- start is ignored while busy; no queueing.
- start and fre_ready may be high simultaneously in DONE: the FSM goes to IDLE, and start is sampled again the following cycle.
- err = (err_code != 0); it is valid only while fre_valid=1.
- gate_len near the maximum: the down-counter wraps nowhere, so the full 2^CNT_WIDTH-1 cycles are honoured.

Optional Feature:
FRE_ROUND_EN
- Defined: in CALC the dividend becomes sig_cnt*CLK_FRE + (gate_cnt>>1), giving round-to-nearest. The dividend widens by 1 bit and DIV takes one extra cycle, so latency becomes N+3+2*CNT_WIDTH.
- Undefined: truncating division with the latency stated above.

Decomposition:
- Shared package (fre_meas_pkg):
  - state enum
  - err_code constants (ERR_OK, ERR_ZERO, ERR_TIMEOUT, ERR_OVF)
  - CNT_WIDTH and CLK_FRE defaults
- Sub-module seq_divider, parameterised width:
  - ports: start, dividend, divisor, done, quotient
  - one bit per cycle
  - reused by later ratio blocks

Test Plan:
- CLK_FRE=200000000, gate_len=16, bench model returns sig_cnt=1000, gate_cnt=200000000 -> cnt_clr pulse of 1 cycle; gate_en high exactly 16 cycles; fre_out=1000, err=0, fre_valid exactly 66 cycles after cnt_valid.
- sig_cnt=3, gate_cnt=7 with CLK_FRE=10 -> fre_out=4 without FRE_ROUND_EN (30/7 truncated); fre_out=4 with it (30+3=33, 33/7 truncated = 4). With sig_cnt=1, gate_cnt=4, CLK_FRE=10: 2 without, 3 with.
- gate_cnt=0 -> err_code=1, fre_out=0; gate_len=0 -> immediate DONE with err_code=3; cnt_valid never asserted -> err_code=2 after exactly 1024 SETTLE cycles.
- sig_cnt=0xFFFFFFFF, gate_cnt=1 -> fre_out=0xFFFFFFFF, err_code=3.
- fre_ready held low 20 cycles in DONE -> fre_out stable, start pulses ignored; fre_ready=1 -> IDLE next cycle and busy=0.
- rst asserted mid-GATE and mid-DIV -> gate_en, busy and fre_valid drop to 0 immediately (asynchronously); next start runs a clean measurement with correct result.
